// File: rtl/hbridge_chopper.sv
// hbridge_chopper: fixed-period peak-current chopper for one H-bridge coil.
// Each period starts at counter 0: if the coil is below target, the bridge
// goes through a dead-time gap into DRIVE. It leaves DRIVE on a current trip
// (after blanking) or at the last count of the period. It then passes through
// another dead-time gap into slow DECAY.
// Optional feature: define HBRIDGE_OC_FAULT_EN to enable the latched
// overcurrent fault against OC_LIMIT.
module hbridge_chopper #(
  parameter int unsigned PERIOD   = 100,
  parameter int unsigned DEADTIME = 2,
  parameter int unsigned BLANK    = 4,
  parameter logic [12:0] OC_LIMIT = 13'd4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        dir,
  input  logic [12:0] target,
  input  logic [12:0] current,
  output logic        s_l1,
  output logic        s_h1,
  output logic        s_l2,
  output logic        s_h2,
  output logic [1:0]  phase,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2,
    DECAY = 2'd3
  } state_t;

  // gate patterns, ordered {s_l1, s_h1, s_l2, s_h2}
  localparam logic [3:0] G_OFF    = 4'b0000;
  localparam logic [3:0] G_DRIVE0 = 4'b1001;
  localparam logic [3:0] G_DRIVE1 = 4'b0110;
  localparam logic [3:0] G_DECAY  = 4'b1010;

  localparam logic [7:0] CntLast   = 8'(PERIOD - 1);
  localparam logic [3:0] DeadLoad  = 4'(DEADTIME - 1);
  localparam logic [3:0] BlankLoad = 4'(BLANK);

  state_t     state;
  state_t     pending;
  logic [7:0] cnt;
  logic [3:0] dead_cnt;
  logic [3:0] blank_cnt;
  logic [3:0] gate_q;
  logic       dir_q;
  logic       start_pend;

  logic       at_start;
  logic       dir_eff;
  logic       want_drive;
  logic       trip;

`ifndef HBRIDGE_OC_FAULT_EN
  logic       unused_oc_limit;
  assign unused_oc_limit = ^OC_LIMIT;
  assign fault = 1'b0;
`endif

  assign {s_l1, s_h1, s_l2, s_h2} = gate_q;
  assign phase = state;

  // period-start, polarity and comparator decodes
  always_comb begin
    at_start   = (cnt == '0);
    dir_eff    = at_start ? dir : dir_q;
    want_drive = (target != '0) && (current < target) && !fault;
    trip       = (blank_cnt == '0) && (current >= target);
  end

  // period counter, parked at 0 while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!enable || cnt == CntLast)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end

  // coil polarity, captured once per period
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dir_q <= 1'b0;
    else if (enable && at_start)
      dir_q <= dir;
  end

  // bridge sequencer with registered gates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= DECAY;
      dead_cnt   <= '0;
      blank_cnt  <= '0;
      start_pend <= 1'b0;
      gate_q     <= G_OFF;
`ifdef HBRIDGE_OC_FAULT_EN
      fault      <= 1'b0;
`endif
    end else if (!enable) begin
      state      <= IDLE;
      start_pend <= 1'b0;
      gate_q     <= G_OFF;
`ifdef HBRIDGE_OC_FAULT_EN
      fault      <= 1'b0;
`endif
    end
`ifdef HBRIDGE_OC_FAULT_EN
    else if (current > OC_LIMIT) begin
      state      <= IDLE;
      start_pend <= 1'b0;
      gate_q     <= G_OFF;
      fault      <= 1'b1;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (at_start && want_drive) begin
            state    <= DEAD;
            pending  <= DRIVE;
            dead_cnt <= DeadLoad;
          end
        end
        DECAY: begin
          // A period start that fell inside the preceding dead gap is
          // honoured here, so max-on-time periods still repeat every PERIOD.
          if (at_start || start_pend) begin
            start_pend <= 1'b0;
            if (want_drive) begin
              state    <= DEAD;
              pending  <= DRIVE;
              dead_cnt <= DeadLoad;
              gate_q   <= G_OFF;
            end
          end
        end
        DEAD: begin
          if (at_start && pending == DECAY)
            start_pend <= 1'b1;
          if (dead_cnt == '0) begin
            state <= pending;
            if (pending == DRIVE) begin
              gate_q    <= dir_eff ? G_DRIVE1 : G_DRIVE0;
              blank_cnt <= BlankLoad;
            end else begin
              gate_q <= G_DECAY;
            end
          end else begin
            dead_cnt <= dead_cnt - 4'd1;
          end
        end
        DRIVE: begin
          if (cnt == CntLast || trip) begin
            state    <= DEAD;
            pending  <= DECAY;
            dead_cnt <= DeadLoad;
            gate_q   <= G_OFF;
          end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          gate_q <= G_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hbridge_chopper.sv
// Directed bench for hbridge_chopper (default parameters) with a simple
// coil model and a continuous bridge-safety monitor.
module tb_hbridge_chopper;

  localparam int DT = 2;
  localparam logic [3:0] G_OFF = 4'b0000;
  localparam logic [3:0] G_D0  = 4'b1001;
  localparam logic [3:0] G_D1  = 4'b0110;
  localparam logic [3:0] G_DEC = 4'b1010;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        dir;
  logic [12:0] target;
  logic [12:0] current;
  logic [12:0] cur_model;
  logic [12:0] cur_force;
  logic        force_on;
  logic        s_l1, s_h1, s_l2, s_h2;
  logic [1:0]  phase;
  logic        fault;

  int vecs = 0;
  int errs = 0;
  int e;

  logic [3:0] prev_cfg = 4'b0000;
  logic [3:0] cfg;
  logic       ok;
  int         off_run = 0;

  hbridge_chopper dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .dir     (dir),
    .target  (target),
    .current (current),
    .s_l1    (s_l1),
    .s_h1    (s_h1),
    .s_l2    (s_l2),
    .s_h2    (s_h2),
    .phase   (phase),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  // coil: ramps one step per cycle while either drive pair conducts
  always @(posedge clk or posedge reset) begin
    if (reset)
      cur_model <= '0;
    else if ((s_l1 & s_h2) | (s_h1 & s_l2))
      cur_model <= cur_model + 13'd1;
    else
      cur_model <= '0;
  end

  assign current = force_on ? cur_force : cur_model;

  // no shoot-through, and every new on-pattern preceded by DT all-off cycles
  always @(negedge clk) begin
    cfg = {s_l1, s_h1, s_l2, s_h2};
    ok  = !(s_l1 && s_h1) && !(s_l2 && s_h2);
    if (cfg != 4'b0000)
      ok = ok && ((prev_cfg != 4'b0000) ? (cfg == prev_cfg) : (off_run >= DT));
    vecs++;
    assert (ok === 1'b1) else begin
      errs++;
      $error("FAIL bridge_guard: gates %b after %b off_run %0d observed ok=%b expected 1",
             cfg, prev_cfg, off_run, ok);
    end
    if (cfg == 4'b0000) off_run++;
    else off_run = 0;
    prev_cfg = cfg;
  end

  function automatic logic [7:0] obs();
    return {fault, 1'b0, phase, s_l1, s_h1, s_l2, s_h2};
  endfunction

  function automatic logic [7:0] ex(input logic f, input logic [1:0] ph, input logic [3:0] g);
    return {f, 1'b0, ph, g};
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp_v);
    logic [7:0] got;
    got = obs();
    vecs++;
    assert (got === exp_v) else begin
      errs++;
      $error("FAIL %s: observed {fault,0,phase,l1h1l2h2}=%b expected %b", tag, got, exp_v);
    end
  endtask

  task automatic adv_to(input int k);
    while (e < k) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic restart(input logic [12:0] tgt, input logic d);
    enable = 1'b0;
    @(negedge clk);
    target = tgt;
    dir    = d;
    enable = 1'b1;
    e      = 0;
  endtask

  initial begin
    #2000000;
    errs++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    dir       = 1'b0;
    target    = 13'd50;
    force_on  = 1'b0;
    cur_force = '0;
    e         = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset", ex(1'b0, 2'd0, G_OFF));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_disabled", ex(1'b0, 2'd0, G_OFF));

    // trip at target 50, dir 0
    enable = 1'b1;
    e = 0;
    adv_to(1);   chk("t50_dead_a",   ex(1'b0, 2'd1, G_OFF));
    adv_to(2);   chk("t50_dead_b",   ex(1'b0, 2'd1, G_OFF));
    adv_to(3);   chk("t50_drive",    ex(1'b0, 2'd2, G_D0));
    adv_to(53);  chk("t50_pre_trip", ex(1'b0, 2'd2, G_D0));
    adv_to(54);  chk("t50_trip",     ex(1'b0, 2'd1, G_OFF));
    adv_to(55);  chk("t50_dead2",    ex(1'b0, 2'd1, G_OFF));
    adv_to(56);  chk("t50_decay",    ex(1'b0, 2'd3, G_DEC));
    adv_to(100); chk("t50_decay_hold", ex(1'b0, 2'd3, G_DEC));
    adv_to(101); chk("t50_next_dead", ex(1'b0, 2'd1, G_OFF));
    adv_to(103); chk("t50_next_drive", ex(1'b0, 2'd2, G_D0));

    // max on-time with unreachable target 500
    restart(13'd500, 1'b0);
    adv_to(3);   chk("mot_drive",   ex(1'b0, 2'd2, G_D0));
    adv_to(99);  chk("mot_last",    ex(1'b0, 2'd2, G_D0));
    adv_to(100); chk("mot_cut",     ex(1'b0, 2'd1, G_OFF));
    adv_to(101); chk("mot_dead",    ex(1'b0, 2'd1, G_OFF));
    adv_to(102); chk("mot_decay",   ex(1'b0, 2'd3, G_DEC));
    adv_to(103); chk("mot_dead2",   ex(1'b0, 2'd1, G_OFF));
    adv_to(105); chk("mot_drive2",  ex(1'b0, 2'd2, G_D0));
    adv_to(199); chk("mot_last2",   ex(1'b0, 2'd2, G_D0));
    adv_to(200); chk("mot_cut2",    ex(1'b0, 2'd1, G_OFF));
    adv_to(202); chk("mot_decay2",  ex(1'b0, 2'd3, G_DEC));
    adv_to(205); chk("mot_drive3",  ex(1'b0, 2'd2, G_D0));

    // dir changed mid-period takes effect next period
    adv_to(240);
    dir = 1'b1;
    adv_to(250); chk("dir_hold",     ex(1'b0, 2'd2, G_D0));
    adv_to(299); chk("dir_hold_end", ex(1'b0, 2'd2, G_D0));
    adv_to(300); chk("dir_cut",      ex(1'b0, 2'd1, G_OFF));
    adv_to(302); chk("dir_decay",    ex(1'b0, 2'd3, G_DEC));
    adv_to(305); chk("dir_new_pair", ex(1'b0, 2'd2, G_D1));

    // target 0 never drives
    restart(13'd0, 1'b0);
    adv_to(1);   chk("tgt0_start",  ex(1'b0, 2'd0, G_OFF));
    adv_to(101); chk("tgt0_period", ex(1'b0, 2'd0, G_OFF));
    adv_to(150); chk("tgt0_mid",    ex(1'b0, 2'd0, G_OFF));

    // enable falling mid-drive
    restart(13'd500, 1'b1);
    adv_to(10);  chk("en_drive_d1", ex(1'b0, 2'd2, G_D1));
    enable = 1'b0;
    adv_to(11);  chk("en_fall",     ex(1'b0, 2'd0, G_OFF));

    // asynchronous reset mid-drive
    restart(13'd500, 1'b0);
    adv_to(10);  chk("rst_pre",     ex(1'b0, 2'd2, G_D0));
    #1 reset = 1'b1;
    #1 chk("rst_async", ex(1'b0, 2'd0, G_OFF));
    #1 reset = 1'b0;
    @(negedge clk); chk("rst_dead_a", ex(1'b0, 2'd1, G_OFF));
    @(negedge clk); chk("rst_dead_b", ex(1'b0, 2'd1, G_OFF));
    @(negedge clk); chk("rst_drive",  ex(1'b0, 2'd2, G_D0));

    // overcurrent spike during drive
    restart(13'd500, 1'b0);
    adv_to(10);
    force_on  = 1'b1;
    cur_force = 13'd4001;
`ifdef HBRIDGE_OC_FAULT_EN
    adv_to(11);  chk("oc_fault",    ex(1'b1, 2'd0, G_OFF));
    force_on = 1'b0;
    adv_to(101); chk("oc_latched",  ex(1'b1, 2'd0, G_OFF));
    enable = 1'b0;
    adv_to(102); chk("oc_cleared",  ex(1'b0, 2'd0, G_OFF));
`else
    adv_to(11);  chk("oc_nofault",  ex(1'b0, 2'd1, G_OFF));
    force_on = 1'b0;
`endif

    // blanking hides an early over-target reading
    enable = 1'b0;
    repeat (2) @(negedge clk);
    target = 13'd1;
    dir    = 1'b0;
    enable = 1'b1;
    e = 0;
    adv_to(7);   chk("blank_hold",  ex(1'b0, 2'd2, G_D0));
    adv_to(8);   chk("blank_trip",  ex(1'b0, 2'd1, G_OFF));

    // random target/dir/enable under the safety monitor
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 99) != 0);
      dir    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0)
        target = 13'($urandom_range(0, 120));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hbridge_chopper.md
HBRIDGE_CHOPPER -- requirements
Module: hbridge_chopper

Interface
REQ-001 Parameter PERIOD, default 100, PWM period in clk cycles (2..255).
REQ-002 Parameter DEADTIME, default 2, all-switches-off cycles inserted at every bridge-state change (1..15).
REQ-003 Parameter BLANK, default 4, cycles after DRIVE entry during which the current comparison is ignored (0..15).
REQ-004 Parameter OC_LIMIT, default 13'd4000, overcurrent threshold (used only with HBRIDGE_OC_FAULT_EN).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  chopper enable; low forces IDLE.
REQ-008 dir  input  1  coil polarity: 0 = s_l1+s_h2 drive, 1 = s_h1+s_l2 drive.
REQ-009 target  input  13  requested peak coil current, unsigned.
REQ-010 current  input  13  measured coil current, unsigned, same scale as target.
REQ-011 s_l1, s_h1, s_l2, s_h2  output  1 each  registered H-bridge switch gates, active-high.
REQ-012 phase  output  2  current state encoding: 0 IDLE, 1 DEAD, 2 DRIVE, 3 DECAY.
REQ-013 fault  output  1  latched overcurrent flag.

Function
REQ-014 Period counter SHALL count 0..PERIOD-1 and wrap while enable=1; held at 0 while enable=0.
REQ-015 dir SHALL be sampled only at counter==0; mid-period dir changes take effect at the next period.
REQ-016 IDLE: all four gates 0.
REQ-017 At counter==0 in IDLE or DECAY with enable=1, fault=0, current<target: go to DEAD, then DRIVE.
REQ-018 DEAD: all gates 0 for exactly DEADTIME cycles, then the pending state (DRIVE or DECAY).
REQ-019 DRIVE: dir=0 -> s_l1=s_h2=1, others 0; dir=1 -> s_h1=s_l2=1, others 0.
REQ-020 DRIVE: after BLANK cycles, current>=target SHALL cause DEAD then DECAY on the next edge.
REQ-021 DRIVE reaching counter==PERIOD-1 without trip SHALL go to DEAD then DECAY (max on-time bound).
REQ-022 DECAY: s_l1=s_l2=1, s_h1=s_h2=0 (slow decay); held until next counter==0 evaluation.
REQ-023 At counter==0 with current>=target, DECAY/IDLE SHALL remain unchanged (skip period).
REQ-024 target==0 SHALL never enter DRIVE.
REQ-025 s_lX and s_hX of the same leg SHALL never both be 1 in any cycle (no shoot-through).
REQ-026 enable falling in any state SHALL force all gates 0 on the next edge and state IDLE.
REQ-027 Gate outputs registered: one cycle from state decision to pin.

Reset
REQ-028 reset=1 SHALL asynchronously set state IDLE, counter 0, all gates 0, phase 0, fault 0.
REQ-029 reset asserted mid-DRIVE SHALL drop all gates immediately, without waiting for clk.

Configuration
REQ-030 Macro HBRIDGE_OC_FAULT_EN defined: current>OC_LIMIT in any state SHALL set fault, force all gates 0 next edge and state IDLE; fault cleared only by reset or enable low.
REQ-031 Macro undefined: fault tied 0, OC_LIMIT ignored, no overcurrent logic.

Verification
REQ-032 Bench with coil model (current +1/cycle while s_l1&s_h2, else 0), dir=0, target=50, defaults: period start -> 2 all-off cycles, DRIVE, current reaches 50, gates off next edge, DEAD 2 cycles, DECAY s_l1=s_l2=1.
REQ-033 target=500, PERIOD=100: DRIVE ends at counter 99 via max on-time, DEAD, DECAY; repeats every 100 cycles.
REQ-034 dir toggled at counter 40: drive pair unchanged until next counter==0, then s_h1+s_l2 driven.
REQ-035 Assertion all cycles, random target/dir/enable: never (s_l1&s_h1) or (s_l2&s_h2); every bridge change preceded by DEADTIME all-off cycles.
REQ-036 reset pulsed mid-DRIVE (no clk edge): gates 0 immediately; after release first DRIVE only after counter==0 plus DEADTIME.
REQ-037 With HBRIDGE_OC_FAULT_EN, force current=4001 during DRIVE: fault=1 and all gates 0 next edge; stays until enable low.
